// File: rtl/tile_render_buffer_pkg.sv
// Shared types and geometry for the tile render buffer: a 16x32 tile of 32-bit pixels.
package tile_pkg;
  localparam int TILE_W_LOG2    = 4;
  localparam int TILE_H_LOG2    = 5;
  localparam int ADDR_W         = TILE_W_LOG2 + TILE_H_LOG2;
  localparam int TILE_WORDS     = 1 << ADDR_W;
  localparam int TILE_ROW_BYTES = 4 << TILE_W_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_START,
    S_ARMED,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/tile_render_buffer_if.sv
// Tile control, pixel write and tile_writer handshake signals of the tile render buffer.
// slave is the buffer's view; master is the producer / tile_writer view.
interface tile_render_buffer_if;
  logic        begin_tile;
  logic        ready_tile;
  logic [7:0]  tile_x;
  logic [7:0]  tile_y;
  logic [31:0] fb_base;
  logic [15:0] fb_stride;
  logic [31:0] clear_color;
  logic        pix_valid;
  logic        pix_ready;
  logic [3:0]  pix_x;
  logic [4:0]  pix_y;
  logic [31:0] pix_color;
  logic [3:0]  pix_byteen;
  logic        tile_end;
  logic        busy;
  logic        tile_done;
  logic        wr_start;
  logic [31:0] wr_addr;
  logic [15:0] wr_stride;
  logic        wr_reading;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;

  modport slave (
    input  begin_tile, tile_x, tile_y, fb_base, fb_stride, clear_color,
    input  pix_valid, pix_x, pix_y, pix_color, pix_byteen, tile_end,
    input  wr_reading, rd_addr,
    output ready_tile, pix_ready, busy, tile_done, wr_start, wr_addr, wr_stride, rd_data
  );

  modport master (
    output begin_tile, tile_x, tile_y, fb_base, fb_stride, clear_color,
    output pix_valid, pix_x, pix_y, pix_color, pix_byteen, tile_end,
    output wr_reading, rd_addr,
    input  ready_tile, pix_ready, busy, tile_done, wr_start, wr_addr, wr_stride, rd_data
  );
endinterface

// File: rtl/tile_render_buffer_ram.sv
// 512x32 simple dual-port tile RAM: byte-enabled write port, registered read (2-cycle latency).
// Same-address read during write returns the old word; no backpressure.
module tile_ram
  import tile_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  logic [31:0]       mem_q [TILE_WORDS];
  logic [ADDR_W-1:0] raddr_q;
  logic [31:0]       rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      raddr_q <= raddr_i;
      rdata_q <= mem_q[raddr_q];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/tile_render_buffer.sv
// Tile colour store: clear (512 cycles), draw pixels, then start tile_writer and wait for it.
// Read data 2 cycles after rd_addr; pix_ready only in DRAW; begin_tile dropped unless ready_tile.
module tile_render_buffer
  import tile_pkg::*;
(
  input  logic                 gpu_clk,
  input  logic                 gpu_rst,
  tile_render_buffer_if.slave  bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        tile_x_q, tile_y_q;
  logic [15:0]       fb_stride_q;
  logic [31:0]       fb_base_q, clear_color_q;
  logic [23:0]       prod_q, prod_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic              tile_done_q, tile_done_d;
  logic              accept, pix_fire;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;

  assign accept   = (state_q == S_IDLE) && bus.begin_tile && !bus.wr_reading;
  assign pix_fire = (state_q == S_DRAW) && bus.pix_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_DRAW;
      end
      S_DRAW:  if (bus.tile_end) state_d = S_START;
      S_START: state_d = S_ARMED;
      S_ARMED: if (bus.wr_reading) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!bus.wr_reading) begin
          state_d     = S_IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      fb_base_q     <= '0;
      fb_stride_q   <= '0;
      clear_color_q <= '0;
    end else if (accept) begin
      tile_x_q      <= bus.tile_x;
      tile_y_q      <= bus.tile_y;
      fb_base_q     <= bus.fb_base;
      fb_stride_q   <= bus.fb_stride;
      clear_color_q <= bus.clear_color;
    end
  end

  // Two-stage origin math; both stages settle long before the clear finishes.
  assign prod_d    = {16'b0, tile_y_q} * {8'b0, fb_stride_q};
  assign wr_addr_d = fb_base_q + (32'(prod_q) << TILE_H_LOG2) + (32'(tile_x_q) * TILE_ROW_BYTES);

  always_ff @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      prod_q    <= '0;
      wr_addr_q <= '0;
    end else if (state_q == S_CLEAR) begin
      prod_q    <= prod_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_waddr = cnt_q;
    ram_wdata = clear_color_q;
    if (state_q == S_CLEAR) begin
      ram_we = 1'b1;
    end else if (pix_fire) begin
      ram_we    = 1'b1;
      ram_be    = bus.pix_byteen;
      ram_waddr = {bus.pix_y, bus.pix_x};
      ram_wdata = bus.pix_color;
    end
  end

  tile_ram u_ram (
    .clk_i   (gpu_clk),
    .rst_i   (gpu_rst),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.ready_tile = (state_q == S_IDLE) && !bus.wr_reading;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.pix_ready  = (state_q == S_DRAW);
  assign bus.wr_start   = (state_q == S_START);
  assign bus.tile_done  = tile_done_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_stride  = fb_stride_q;
endmodule
